// File: rtl/cc_itf_pkg.sv
// Shared CoreComplex interface types for the 32b APB segment and the
// register-file completer state encoding.
package cc_itf_pkg;

  localparam int unsigned APB_ADDR_W = 32;
  localparam int unsigned APB_REG_W  = 32;
  localparam int unsigned APB_STRB_W = APB_REG_W / 8;

  typedef struct packed {
    logic [APB_ADDR_W-1:0] paddr;
    logic [2:0]            pprot;
    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [APB_REG_W-1:0]  pwdata;
    logic [APB_STRB_W-1:0] pstrb;
  } apb_d32_req_t;

  typedef struct packed {
    logic                 pready;
    logic [APB_REG_W-1:0] prdata;
    logic                 pslverr;
  } apb_d32_resps_t;

  typedef enum logic [1:0] {
    APB_IDLE,
    APB_WAIT,
    APB_DONE
  } apb_slv_state_e;

  // Byte-lane merge of new write data into an existing register word.
  function automatic logic [APB_REG_W-1:0] apb_strb_merge(
    input logic [APB_REG_W-1:0]  old_q,
    input logic [APB_REG_W-1:0]  wdata,
    input logic [APB_STRB_W-1:0] strb
  );
    logic [APB_REG_W-1:0] res;
    res = old_q;
    for (int b = 0; b < int'(APB_STRB_W); b++) begin
      if (strb[b]) res[8*b +: 8] = wdata[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/cc_apb_wait_cnt.sv
// Wait-state counter: loads a start value, counts down to zero and flags the
// zero and one states so the FSM can raise pready on the final decrement.
module cc_apb_wait_cnt (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_load,
  input  logic [3:0] i_load_val,
  input  logic       i_dec,
  output logic       o_zero,
  output logic       o_one
);

  logic [3:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt <= 4'd0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != 4'd0)) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  assign o_zero = (r_cnt == 4'd0);
  assign o_one  = (r_cnt == 4'd1);

endmodule

// File: rtl/cc_apb_d32_regfile_slv.sv
// APB completer: a bank of NUM_REGS 32b registers with byte strobes, wait
// states, range/RO/privilege error responses and a hardware-side write port.
module cc_apb_d32_regfile_slv
  import cc_itf_pkg::*;
#(
  parameter int unsigned            NUM_REGS    = 8,
  parameter logic [31:0]            BASE_ADDR   = 32'h0,
  parameter int unsigned            WAIT_CYCLES = 0,
  parameter logic [NUM_REGS-1:0]    RO_MASK     = '0,
  parameter logic [NUM_REGS*32-1:0] RESET_VAL   = '0,
  parameter logic                   PRIV_ONLY   = 1'b0,
  localparam int unsigned           IDX_W       = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  apb_d32_req_t           apb_req_i,
  output apb_d32_resps_t         apb_resp_o,
  input  logic                   hw_we_i,
  input  logic [IDX_W-1:0]       hw_idx_i,
  input  logic [31:0]            hw_wdata_i,
  output logic [NUM_REGS*32-1:0] reg_q_o
);

  // RO mask widened to every encodable index so decode never reads past it.
  localparam int unsigned        NSLOT   = 1 << IDX_W;
  localparam logic [NSLOT-1:0]   RO_EXT  = NSLOT'(RO_MASK);
  localparam logic [3:0]         WAIT_LD = 4'(WAIT_CYCLES);
  localparam logic               W_ZERO  = (WAIT_CYCLES == 0);

  apb_slv_state_e r_state;
  apb_slv_state_e w_state_nxt;

  logic [31:0]      r_regs [NUM_REGS];
  logic             r_pready;
  logic             r_pslverr;
  logic [31:0]      r_prdata;

  logic [31:0]      w_off;
  logic             w_hit;
  logic [IDX_W-1:0] w_idx;
  logic             w_err;
  logic [31:0]      w_rdata;
  logic             w_setup;
  logic             w_access;
  logic             w_cnt_load;
  logic             w_cnt_dec;
  logic             w_cnt_zero;
  logic             w_cnt_one;
  logic             w_commit;
  logic             w_apb_wr;
  logic             w_unused;

  assign w_off    = apb_req_i.paddr - BASE_ADDR;
  assign w_hit    = (apb_req_i.paddr >= BASE_ADDR) && ({2'b00, w_off[31:2]} < NUM_REGS);
  assign w_idx    = w_off[2 +: IDX_W];
  assign w_err    = !w_hit
                 || (apb_req_i.pwrite && RO_EXT[w_idx])
                 || (PRIV_ONLY && !apb_req_i.pprot[0]);
  assign w_setup  = apb_req_i.psel && !apb_req_i.penable;
  assign w_access = apb_req_i.psel && apb_req_i.penable;
  assign w_apb_wr = w_commit && apb_req_i.pwrite && !w_err;
  assign w_unused = ^{apb_req_i.pprot[2:1], w_off[1:0]};

  always_comb begin
    w_rdata = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (w_idx == IDX_W'(i)) w_rdata = r_regs[i];
    end
  end

  cc_apb_wait_cnt u_wait_cnt (
    .i_clk      (clk_i),
    .i_rst_n    (rst_ni),
    .i_load     (w_cnt_load),
    .i_load_val (WAIT_LD),
    .i_dec      (w_cnt_dec),
    .o_zero     (w_cnt_zero),
    .o_one      (w_cnt_one)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= APB_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A SETUP seen in any state (re)starts the count; losing psel aborts.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_load  = 1'b0;
    w_cnt_dec   = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      APB_IDLE: begin
        if (w_setup) begin
          w_cnt_load  = 1'b1;
          w_state_nxt = W_ZERO ? APB_DONE : APB_WAIT;
        end
      end
      APB_WAIT: begin
        if (w_setup) begin
          w_cnt_load  = 1'b1;
          w_state_nxt = W_ZERO ? APB_DONE : APB_WAIT;
        end else if (w_access) begin
          w_cnt_dec = 1'b1;
          if (w_cnt_one || w_cnt_zero) w_state_nxt = APB_DONE;
        end else begin
          w_state_nxt = APB_IDLE;
        end
      end
      APB_DONE: begin
        if (w_access) begin
          w_commit    = 1'b1;
          w_state_nxt = APB_IDLE;
        end else if (w_setup) begin
          w_cnt_load  = 1'b1;
          w_state_nxt = W_ZERO ? APB_DONE : APB_WAIT;
        end else begin
          w_state_nxt = APB_IDLE;
        end
      end
      default: w_state_nxt = APB_IDLE;
    endcase
  end

  // Response is captured on the edge entering DONE, from the stable address.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
      r_prdata  <= '0;
    end else if (w_state_nxt == APB_DONE) begin
      r_pready  <= 1'b1;
      r_pslverr <= w_err;
      r_prdata  <= (w_err || apb_req_i.pwrite) ? '0 : w_rdata;
    end else begin
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
      r_prdata  <= '0;
    end
  end

  // APB commit takes priority over a same-edge hardware write to that register.
  always_ff @(posedge clk_i) begin
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (!rst_ni) begin
        r_regs[i] <= RESET_VAL[32*i +: 32];
      end else if (w_apb_wr && (w_idx == IDX_W'(i))) begin
        r_regs[i] <= apb_strb_merge(r_regs[i], apb_req_i.pwdata, apb_req_i.pstrb);
      end else if (hw_we_i && (hw_idx_i == IDX_W'(i))) begin
        r_regs[i] <= hw_wdata_i;
      end
    end
  end

  assign apb_resp_o = '{pready: r_pready, prdata: r_prdata, pslverr: r_pslverr};

  for (genvar g = 0; g < int'(NUM_REGS); g++) begin : g_regq
    assign reg_q_o[32*g +: 32] = r_regs[g];
  end

endmodule
